// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I OP/OP-IMM issue stage in front of the integer ALU.
// Decodes the incoming word, reads the register file (with writeback
// bypass), and holds a registered {inst, a, b, rd} bundle for the ALU
// behind a valid/ready handshake. Also owns the register file write port.
module alu_issue_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_inst,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [4:0]      out_rd,
  output logic            out_illegal,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // Architectural registers; entry 0 exists but is never written.
  logic [XLEN-1:0] r_regfile [NREG];

  logic            r_outValid;
  logic [2:0]      r_outInst;
  logic [XLEN-1:0] r_outA;
  logic [XLEN-1:0] r_outB;
  logic [4:0]      r_outRd;
  logic            r_outIllegal;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_rs1Data;
  logic [XLEN-1:0] w_rs2Data;
  logic            w_legal;
  logic            w_isOp;
  logic            w_wbActive;
  logic            w_accept;

  assign w_opcode = in_instr[6:0];
  assign w_funct3 = in_instr[14:12];
  assign w_funct7 = in_instr[31:25];
  assign w_rs1    = in_instr[19:15];
  assign w_rs2    = in_instr[24:20];
  assign w_rd     = in_instr[11:7];
  assign w_imm    = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};

  assign w_wbActive = wb_en && (wb_rd != 5'd0);
  assign in_ready   = !r_outValid || out_ready;
  assign w_accept   = in_valid && in_ready;

  // Operand read: x0 is zero, a same-cycle writeback to the source wins.
  always_comb begin
    w_rs1Data = '0;
    w_rs2Data = '0;
    if (w_rs1 != 5'd0) begin
      if (w_wbActive && (wb_rd == w_rs1)) w_rs1Data = wb_data;
      else                                w_rs1Data = r_regfile[w_rs1];
    end
    if (w_rs2 != 5'd0) begin
      if (w_wbActive && (wb_rd == w_rs2)) w_rs2Data = wb_data;
      else                                w_rs2Data = r_regfile[w_rs2];
    end
  end

  // Legality: OP needs funct7 zero; OP-IMM shifts need funct7 zero too.
  always_comb begin
    w_legal = 1'b0;
    w_isOp  = 1'b0;
    if (w_opcode == OPC_OP) begin
      w_isOp  = 1'b1;
      w_legal = (w_funct7 == 7'b0000000);
    end else if (w_opcode == OPC_OP_IMM) begin
      if ((w_funct3 == 3'b001) || (w_funct3 == 3'b101))
        w_legal = (w_funct7 == 7'b0000000);
      else
        w_legal = 1'b1;
    end
  end

  // Issue register: load on accept, drop valid once consumed, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outValid   <= 1'b0;
      r_outInst    <= '0;
      r_outA       <= '0;
      r_outB       <= '0;
      r_outRd      <= '0;
      r_outIllegal <= 1'b0;
    end else if (w_accept) begin
      r_outValid <= 1'b1;
      if (w_legal) begin
        r_outInst    <= w_funct3;
        r_outA       <= w_rs1Data;
        r_outB       <= w_isOp ? w_rs2Data : w_imm;
        r_outRd      <= w_rd;
        r_outIllegal <= 1'b0;
      end else begin
        r_outInst    <= '0;
        r_outA       <= '0;
        r_outB       <= '0;
        r_outRd      <= '0;
        r_outIllegal <= 1'b1;
      end
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  // Register file write port, driven by writeback independently of issue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regfile[i] <= '0;
    end else if (w_wbActive) begin
      r_regfile[wb_rd] <= wb_data;
    end
  end

  assign out_valid   = r_outValid;
  assign out_inst    = r_outInst;
  assign out_a       = r_outA;
  assign out_b       = r_outB;
  assign out_rd      = r_outRd;
  assign out_illegal = r_outIllegal;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Issue stage directly upstream of the RV32I integer ALU.
- Decodes OP and OP-IMM instruction words and reads the 32x32 integer register file, with write-to-read bypass.
- Presents a registered {inst, a, b, rd} bundle to the ALU over a valid/ready handshake.
- Owns the register file write port, which the downstream writeback drives.

Parameters:
- XLEN, 32, data width of registers and operands (only 32 supported).
- NREG, 32, number of architectural registers; x0 hardwired to zero.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  stage can accept an instruction this cycle.
- in_instr  input  32  RV32I instruction word.
- out_valid  output  1  issue bundle valid.
- out_ready  input  1  ALU side accepts the bundle.
- out_inst  output  3  ALU opcode (funct3 encoding).
- out_a  output  XLEN  operand A.
- out_b  output  XLEN  operand B.
- out_rd  output  5  destination register.
- out_illegal  output  1  instruction was not executable by the ALU.
- wb_en  input  1  register file write enable.
- wb_rd  input  5  write address.
- wb_data  input  XLEN  write data.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - out_valid, out_inst, out_a, out_b, out_rd and out_illegal all go to 0.
  - All registers x1..x31 are cleared to 0.
  - A writeback presented during reset is ignored.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - An instruction is accepted when in_valid && in_ready; the bundle is registered and out_valid=1 the next cycle (1-cycle latency).
  - The bundle is consumed when out_valid && out_ready. If no new instruction is accepted in that cycle, out_valid goes to 0.
  - Accept and consume in the same cycle give back-to-back throughput of 1 instruction per cycle.
  - While out_valid && !out_ready, all out_* signals hold stable.
- Decode (opcode = instr[6:0], funct3 = instr[14:12], funct7 = instr[31:25], rs1 = instr[19:15], rs2 = instr[24:20], rd = instr[11:7]):
  - ALU opcode map: 000 add, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl, 110 or, 111 and.
  - 0110011 OP:
    - a = R[rs1], b = R[rs2], inst = funct3.
    - funct7 must be 0000000; anything else (including SUB and SRA) is illegal.
  - 0010011 OP-IMM:
    - a = R[rs1], b = sign-extended instr[31:20], inst = funct3.
    - For funct3 001 and 101, funct7 must be 0000000; SRAI and other values are illegal.
    - For funct3 001 and 101, b is the full sign-extended immediate; the ALU uses b[4:0].
  - Any other opcode is illegal.
  - An illegal instruction is still accepted and issued with out_illegal=1, out_inst=000, out_a=0, out_b=0, out_rd=0.
- Register read:
  - R[0] always reads 0.
  - If wb_en && wb_rd != 0 && wb_rd == rs in the accept cycle, the read returns wb_data (bypass).
  - Operands are captured only at acceptance. A writeback while the bundle is held does not alter out_a/out_b; RAW hazards beyond the bypass are resolved upstream.
- Writeback:
  - When wb_en && wb_rd != 0, R[wb_rd] is updated at the clk edge.
  - Writes to x0 are discarded.
  - Writeback is independent of the handshake and may occur every cycle, including while stalled.
- Width rules: all operand paths are XLEN; the immediate is sign-extended from bit 31.

Test Plan:
- Reset, then accept ADDI x1,x0,-5 (0xFFB00093) -> next cycle out_valid=1, out_inst=000, out_a=0, out_b=0xFFFFFFFB, out_rd=1, out_illegal=0.
- Write wb x2=0x12345678 and, in the same cycle, accept XOR x3,x2,x2 -> out_a=out_b=0x12345678 via bypass. Write wb x0=7, then accept an instr reading x0 -> operand reads 0.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and all out_* stable. A wb to the held rs1 during the stall does not change out_a. Release -> the next instruction issues on the following cycle.
- Stream 4 back-to-back OP instructions with out_ready=1 -> 4 consecutive out_valid cycles, order preserved.
- Issue SUB (funct7=0100000), SRAI, and opcode 0000011 -> each gives out_illegal=1, out_inst=0, out_a=out_b=0, out_rd=0.
- Assert rst_n=0 while out_valid=1 and stalled -> next cycle out_valid=0 and registers read 0.
